// File: rtl/rstp_h2t_desc_pusher_pkg.sv
// Shared definitions for the H2T descriptor pusher: debug-IP CSR offsets,
// the slot-read fault marker and the controller state encoding.
package rstp_h2t_pkg;

  localparam logic [31:0] CSR_SLOT_AVAIL = 32'h0000_0100;
  localparam logic [31:0] CSR_DESC_LEN   = 32'h0000_0108;
  localparam logic [31:0] CSR_DESC_LOC   = 32'h0000_010C;
  localparam logic [31:0] CSR_DESC_CONN  = 32'h0000_0110;
  localparam logic [31:0] CSR_DESC_CHAN  = 32'h0000_0114;

  localparam logic [31:0] SLOT_FAULT     = 32'hDEAD_C0DE;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHK,
    ST_RD_SLOT,
    ST_RD_WAIT,
    ST_GAP,
    ST_WR_LOC,
    ST_WR_CONN,
    ST_WR_CHAN,
    ST_WR_LEN
  } state_e;

endpackage

// File: rtl/rstp_h2t_desc_pusher.sv
// Pushes one H2T descriptor into the remote-STP debug IP per accepted request,
// polling the IP's free-slot count so its descriptor FIFO is never overrun.
module rstp_h2t_desc_pusher
  import rstp_h2t_pkg::*;
#(
  parameter logic [31:0] DBG_BASE   = 32'h0009_4000,
  parameter int unsigned MEM_DEPTH  = 4096,
  parameter int unsigned DESC_DEPTH = 32,
  parameter int unsigned POLL_GAP   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_start_loc,
  input  logic [30:0] req_len,
  input  logic        req_last,
  input  logic [31:0] req_conn_id,
  input  logic [31:0] req_chan_id,
  output logic [31:0] avmm_address,
  output logic        avmm_write,
  output logic        avmm_read,
  output logic [31:0] avmm_writedata,
  output logic [3:0]  avmm_byteenable,
  input  logic        avmm_waitrequest,
  input  logic [31:0] avmm_readdata,
  input  logic        avmm_readdatavalid,
  output logic [5:0]  credits,
  output logic        err_len,
  output logic        err_fault,
  output logic [15:0] desc_cnt
);

  state_e      state_q, state_d;
  logic [5:0]  credits_q, credits_d;
  logic [15:0] desc_cnt_q, desc_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [31:0] loc_q, loc_d;
  logic [30:0] len_q, len_d;
  logic        last_q, last_d;
  logic [31:0] conn_q, conn_d;
  logic [31:0] chan_q, chan_d;
  logic [5:0]  slot_credits;

  // Zero length or a region running past the end of the H2T buffer.
  function automatic logic range_bad(input logic [31:0] start, input logic [30:0] len);
    logic [32:0] end_byte;
    end_byte = {1'b0, start} + {2'b0, len};
    return (len == '0) || (end_byte > 33'(MEM_DEPTH));
  endfunction

  function automatic logic [5:0] clamp_slots(input logic [31:0] raw);
    if (raw > 32'(DESC_DEPTH)) return 6'(DESC_DEPTH);
    return raw[5:0];
  endfunction

  assign credits         = credits_q;
  assign desc_cnt        = desc_cnt_q;
  assign avmm_byteenable = 4'hF;

  always_comb begin
    state_d        = state_q;
    credits_d      = credits_q;
    desc_cnt_d     = desc_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    loc_d          = loc_q;
    len_d          = len_q;
    last_d         = last_q;
    conn_d         = conn_q;
    chan_d         = chan_q;
    slot_credits   = '0;
    avmm_address   = '0;
    avmm_write     = 1'b0;
    avmm_read      = 1'b0;
    avmm_writedata = '0;
    req_ready      = 1'b0;
    err_len        = 1'b0;
    err_fault      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) state_d = ST_CHK;
      end
      ST_CHK: begin
        loc_d  = req_start_loc;
        len_d  = req_len;
        last_d = req_last;
        conn_d = req_conn_id;
        chan_d = req_chan_id;
        if (range_bad(req_start_loc, req_len)) begin
          req_ready = 1'b1;
          err_len   = 1'b1;
          state_d   = ST_IDLE;
        end else if (credits_q == '0) begin
          state_d = ST_RD_SLOT;
        end else begin
          state_d = ST_WR_LOC;
        end
      end
      ST_RD_SLOT: begin
        avmm_read    = 1'b1;
        avmm_address = DBG_BASE + CSR_SLOT_AVAIL;
        if (!avmm_waitrequest) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (avmm_readdatavalid) begin
          // A faulted slot read is treated as "no room" and re-polled.
          if (avmm_readdata == SLOT_FAULT) begin
            err_fault = 1'b1;
          end else begin
            slot_credits = clamp_slots(avmm_readdata);
          end
          credits_d = slot_credits;
          if (slot_credits != '0) begin
            state_d = ST_WR_LOC;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 16'(POLL_GAP - 1)) state_d = ST_RD_SLOT;
        else gap_cnt_d = gap_cnt_q + 16'd1;
      end
      ST_WR_LOC: begin
        avmm_write     = 1'b1;
        avmm_address   = DBG_BASE + CSR_DESC_LOC;
        avmm_writedata = loc_q;
        if (!avmm_waitrequest) state_d = ST_WR_CONN;
      end
      ST_WR_CONN: begin
        avmm_write     = 1'b1;
        avmm_address   = DBG_BASE + CSR_DESC_CONN;
        avmm_writedata = conn_q;
        if (!avmm_waitrequest) state_d = ST_WR_CHAN;
      end
      ST_WR_CHAN: begin
        avmm_write     = 1'b1;
        avmm_address   = DBG_BASE + CSR_DESC_CHAN;
        avmm_writedata = chan_q;
        if (!avmm_waitrequest) state_d = ST_WR_LEN;
      end
      ST_WR_LEN: begin
        // The length write commits the descriptor inside the IP.
        avmm_write     = 1'b1;
        avmm_address   = DBG_BASE + CSR_DESC_LEN;
        avmm_writedata = {last_q, len_q};
        if (!avmm_waitrequest) begin
          req_ready  = 1'b1;
          credits_d  = credits_q - 6'd1;
          desc_cnt_d = desc_cnt_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      credits_q  <= '0;
      desc_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      credits_q  <= credits_d;
      desc_cnt_q <= desc_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // Request holding registers: only meaningful once CHK has loaded them.
  always_ff @(posedge clk) begin
    loc_q  <= loc_d;
    len_q  <= len_d;
    last_q <= last_d;
    conn_q <= conn_d;
    chan_q <= chan_d;
  end

endmodule

// File: tb/tb_rstp_h2t_desc_pusher.sv
// Bench for rstp_h2t_desc_pusher: an AVMM slave with stalls and read latency,
// plus a request-level reference model of credits, polls and CSR writes.
module tb_rstp_h2t_desc_pusher;

  localparam logic [31:0] BASE     = 32'h0009_4000;
  localparam int          POLL_GAP = 16;
  localparam int          RD_LAT   = 2;
  localparam logic [31:0] FAULT    = 32'hDEAD_C0DE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_start_loc;
  logic [30:0] req_len;
  logic        req_last;
  logic [31:0] req_conn_id, req_chan_id;
  logic [31:0] avmm_address, avmm_writedata, avmm_readdata;
  logic        avmm_write, avmm_read, avmm_waitrequest, avmm_readdatavalid;
  logic [3:0]  avmm_byteenable;
  logic [5:0]  credits;
  logic        err_len, err_fault;
  logic [15:0] desc_cnt;

  rstp_h2t_desc_pusher dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_start_loc      (req_start_loc),
    .req_len            (req_len),
    .req_last           (req_last),
    .req_conn_id        (req_conn_id),
    .req_chan_id        (req_chan_id),
    .avmm_address       (avmm_address),
    .avmm_write         (avmm_write),
    .avmm_read          (avmm_read),
    .avmm_writedata     (avmm_writedata),
    .avmm_byteenable    (avmm_byteenable),
    .avmm_waitrequest   (avmm_waitrequest),
    .avmm_readdata      (avmm_readdata),
    .avmm_readdatavalid (avmm_readdatavalid),
    .credits            (credits),
    .err_len            (err_len),
    .err_fault          (err_fault),
    .desc_cnt           (desc_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed bus activity.
  int          cyc = 0;
  int          overlap_cnt = 0, unstable_cnt = 0, rd_addr_bad = 0, be_bad = 0;
  int          ready_cnt = 0, errlen_cnt = 0, fault_cnt = 0;
  logic [63:0] wr_log[$];
  int          rd_cycles[$];

  // Slave configuration and the slot values it will return.
  int          stall_n = 0;
  bit          spur_en = 1'b0;
  logic [31:0] slot_q[$];

  // Reference model state.
  int          m_credits = 0, m_desc = 0;
  int          exp_ready = 0, exp_errlen = 0, exp_fault = 0, exp_reads = 0;
  logic [31:0] model_q[$];
  logic [63:0] exp_wr[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic finish_run();
    chk("rw_overlap", 64'(overlap_cnt), 64'd0);
    chk("wr_stable", 64'(unstable_cnt), 64'd0);
    chk("rd_address", 64'(rd_addr_bad), 64'd0);
    chk("byteenable", 64'(be_bad), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // AVMM slave: per-transaction stall of stall_n cycles, fixed read latency,
  // and optional spurious readdatavalid pulses while no read is in flight.
  initial begin
    int stall_left;
    int rd_cd;
    bit in_txn;
    stall_left = 0; rd_cd = 0; in_txn = 1'b0;
    avmm_waitrequest = 1'b0; avmm_readdatavalid = 1'b0; avmm_readdata = '0;
    forever begin
      @(posedge clk); #1;
      avmm_readdatavalid = 1'b0;
      if (!rst_n) begin
        rd_cd = 0; in_txn = 1'b0; avmm_waitrequest = 1'b0;
      end else begin
        if (rd_cd > 0) begin
          rd_cd--;
          if (rd_cd == 0) begin
            avmm_readdatavalid = 1'b1;
            avmm_readdata = (slot_q.size() > 0) ? slot_q.pop_front() : 32'd32;
          end
        end else if (spur_en && !avmm_read && $urandom_range(0, 7) == 0) begin
          avmm_readdatavalid = 1'b1;
          avmm_readdata = FAULT;
        end
        if (avmm_write || avmm_read) begin
          if (!in_txn) begin in_txn = 1'b1; stall_left = stall_n; end
          if (stall_left > 0) begin
            avmm_waitrequest = 1'b1;
            stall_left--;
          end else begin
            avmm_waitrequest = 1'b0;
            in_txn = 1'b0;
            if (avmm_read) rd_cd = RD_LAT;
          end
        end else begin
          avmm_waitrequest = 1'b0;
        end
      end
    end
  end

  // Bus monitor, sampling on the falling edge.
  initial begin
    bit          stalling;
    logic [63:0] held;
    stalling = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) stalling = 1'b0;
      if (avmm_write && avmm_read) overlap_cnt++;
      if (avmm_byteenable !== 4'hF) be_bad++;
      if (avmm_write) begin
        if (stalling && {avmm_address, avmm_writedata} !== held) unstable_cnt++;
        if (avmm_waitrequest) begin
          if (!stalling) begin stalling = 1'b1; held = {avmm_address, avmm_writedata}; end
        end else begin
          wr_log.push_back({avmm_address, avmm_writedata});
          stalling = 1'b0;
        end
      end
      if (avmm_read && !avmm_waitrequest) begin
        rd_cycles.push_back(cyc);
        if (avmm_address !== BASE + 32'h100) rd_addr_bad++;
      end
      if (req_ready) ready_cnt++;
      if (err_len) errlen_cnt++;
      if (err_fault) fault_cnt++;
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic push_slot(input logic [31:0] v);
    slot_q.push_back(v);
    model_q.push_back(v);
  endtask

  // Request-level model: reject, else poll until slots exist, then four writes.
  task automatic model_req(input logic [31:0] s, input logic [30:0] l, input logic last,
                           input logic [31:0] conn, input logic [31:0] chan);
    longint unsigned end_byte;
    logic [31:0]     v;
    end_byte = longint'(s) + longint'(l);
    exp_ready++;
    if (l == 0 || end_byte > 64'd4096) begin
      exp_errlen++;
      return;
    end
    while (m_credits == 0) begin
      v = (model_q.size() > 0) ? model_q.pop_front() : 32'd32;
      exp_reads++;
      if (v == FAULT) begin exp_fault++; m_credits = 0; end
      else m_credits = (v > 32) ? 32 : int'(v);
    end
    exp_wr.push_back({BASE + 32'h10C, s});
    exp_wr.push_back({BASE + 32'h110, conn});
    exp_wr.push_back({BASE + 32'h114, chan});
    exp_wr.push_back({BASE + 32'h108, last, l});
    m_credits--;
    m_desc = (m_desc + 1) % 65536;
  endtask

  task automatic run_req(input logic [31:0] s, input logic [30:0] l, input logic last,
                         input logic [31:0] conn, input logic [31:0] chan, output int lat);
    model_req(s, l, last, conn, chan);
    @(negedge clk);
    req_start_loc = s; req_len = l; req_last = last;
    req_conn_id = conn; req_chan_id = chan; req_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!req_ready && lat < 3000);
    if (!req_ready) begin
      chk("req_ready_timeout", 64'd0, 64'd1);
      finish_run();
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_start_loc = $urandom; req_conn_id = $urandom; req_chan_id = $urandom;
    @(negedge clk);
  endtask

  task automatic compare_state(input string tag);
    logic [63:0] a, b;
    chk({tag, "_credits"}, 64'(credits), 64'(m_credits));
    chk({tag, "_desc_cnt"}, 64'(desc_cnt), 64'(m_desc));
    chk({tag, "_ready_pulses"}, 64'(ready_cnt), 64'(exp_ready));
    chk({tag, "_err_len_pulses"}, 64'(errlen_cnt), 64'(exp_errlen));
    chk({tag, "_err_fault_pulses"}, 64'(fault_cnt), 64'(exp_fault));
    chk({tag, "_slot_reads"}, 64'(rd_cycles.size()), 64'(exp_reads));
    chk({tag, "_nwrites"}, 64'(wr_log.size()), 64'(exp_wr.size()));
    while (wr_log.size() > 0 && exp_wr.size() > 0) begin
      a = wr_log.pop_front();
      b = exp_wr.pop_front();
      chk({tag, "_write"}, a, b);
    end
    wr_log.delete();
    exp_wr.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_credits = 0; m_desc = 0;
    wr_log.delete(); exp_wr.delete();
    slot_q.delete(); model_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_write"}, 64'(avmm_write), 64'd0);
    chk({tag, "_read"}, 64'(avmm_read), 64'd0);
    chk({tag, "_address"}, 64'(avmm_address), 64'd0);
    chk({tag, "_writedata"}, 64'(avmm_writedata), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_err_len"}, 64'(err_len), 64'd0);
    chk({tag, "_err_fault"}, 64'(err_fault), 64'd0);
    chk({tag, "_credits"}, 64'(credits), 64'd0);
    chk({tag, "_desc_cnt"}, 64'(desc_cnt), 64'd0);
  endtask

  initial begin
    int          lat, n, r0;
    logic [31:0] s;
    logic [30:0] l;
    rst_n = 1'b0; req_valid = 1'b0; req_start_loc = '0; req_len = '0;
    req_last = 1'b0; req_conn_id = '0; req_chan_id = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Basic descriptor after a slot read of 32.
    push_slot(32'd32);
    run_req(32'd0, 31'd64, 1'b1, 32'd5, 32'd2, lat);
    chk("t1_len_word", (wr_log.size() == 4) ? wr_log[3] : 64'd0, {32'h0009_4108, 32'h8000_0040});
    chk("t1_credits_const", 64'(credits), 64'd31);
    compare_state("t1");

    // Credits available, no stalls: IDLE, CHK and four writes.
    run_req(32'd100, 31'd16, 1'b0, 32'd7, 32'd9, lat);
    chk("min_latency", 64'(lat + 1), 64'd6);
    compare_state("t2");

    // Three-cycle stall on every write.
    stall_n = 3;
    run_req(32'd2048, 31'd1000, 1'b1, 32'hA5A5_0001, 32'h0000_00C3, lat);
    compare_state("stall");
    stall_n = 0;

    // Two empty polls then one slot.
    do_reset();
    r0 = rd_cycles.size();
    push_slot(32'd0); push_slot(32'd0); push_slot(32'd1);
    run_req(32'd10, 31'd20, 1'b0, 32'd1, 32'd3, lat);
    n = rd_cycles.size();
    chk("poll_reads", 64'(n - r0), 64'd3);
    if (n - r0 == 3) begin
      chk("poll_spacing_1", 64'(rd_cycles[r0 + 1] - rd_cycles[r0]), 64'(POLL_GAP + RD_LAT + 1));
      chk("poll_spacing_2", 64'(rd_cycles[r0 + 2] - rd_cycles[r0 + 1]), 64'(POLL_GAP + RD_LAT + 1));
    end
    compare_state("poll");

    // Rejections with zero credits cached: no AVMM traffic at all.
    run_req(32'd0, 31'd0, 1'b1, 32'd1, 32'd1, lat);
    compare_state("bad_len0");
    run_req(32'd4000, 31'd200, 1'b0, 32'd1, 32'd1, lat);
    compare_state("bad_range");
    run_req(32'd4000, 31'h4000_0000, 1'b0, 32'd1, 32'd1, lat);
    compare_state("bad_huge");
    push_slot(32'd3);
    run_req(32'd4000, 31'd96, 1'b1, 32'd2, 32'd4, lat);
    compare_state("edge_fit");

    // Faulted slot read, then a good one.
    do_reset();
    r0 = rd_cycles.size();
    push_slot(FAULT); push_slot(32'd5);
    run_req(32'd300, 31'd40, 1'b0, 32'd11, 32'd12, lat);
    if (rd_cycles.size() - r0 == 2)
      chk("fault_repoll", 64'(rd_cycles[r0 + 1] - rd_cycles[r0]), 64'(POLL_GAP + RD_LAT + 1));
    compare_state("fault");

    // Reset while the connection-id write is on the bus.
    @(negedge clk);
    req_start_loc = 32'd64; req_len = 31'd8; req_last = 1'b1;
    req_conn_id = 32'h55; req_chan_id = 32'h66; req_valid = 1'b1;
    n = 0;
    while (!(avmm_write && avmm_address == BASE + 32'h110) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_at_wr_conn", 64'(avmm_address), 64'(BASE + 32'h110));
    rst_n = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    m_credits = 0; m_desc = 0;
    wr_log.delete(); exp_wr.delete();
    r0 = rd_cycles.size();
    push_slot(32'd2);
    run_req(32'd64, 31'd8, 1'b1, 32'h55, 32'h66, lat);
    chk("post_rst_polls", 64'(rd_cycles.size() - r0), 64'd1);
    compare_state("post_rst");

    // Randomized traffic with stalls and stray readdatavalid pulses.
    spur_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      stall_n = int'($urandom_range(0, 2));
      s = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0:       l = '0;
          1:       l = 31'(4097 - int'(s) + int'($urandom_range(0, 99)));
          default: l = {1'b1, 30'($urandom)};
        endcase
      end else begin
        l = 31'($urandom_range(1, 4096 - int'(s)));
        if (m_credits == 0 && model_q.size() == 0) begin
          for (int k = 0; k < int'($urandom_range(0, 2)); k++)
            push_slot(($urandom_range(0, 1) == 0) ? 32'd0 : FAULT);
          push_slot(($urandom_range(0, 4) == 0) ? 32'($urandom_range(33, 60))
                                                : 32'($urandom_range(1, 6)));
        end
      end
      run_req(s, l, 1'($urandom_range(0, 1)), $urandom, $urandom, lat);
      compare_state("rand");
    end
    spur_en = 1'b0;
    stall_n = 0;

    repeat (5) @(negedge clk);
    finish_run();
  end

endmodule
